// File: rtl/usrt_tx_param_pkg.sv
// usrt_pkg: shared definitions for the parametrised USRT transmitter.
//   state_e     serialiser FSM state encoding
//   PAR_*       parity mode selectors for the PARITY_MODE parameter
package usrt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/usrt_tx_fifo.sv
// usrt_tx_fifo: synchronous show-ahead FIFO in front of the serialiser.
// Built only when USRT_TX_FIFO_EN is defined.
//   clk_i, rst_ni         clock, async active-low reset (empties the FIFO)
//   wr_en_i, wr_data_i    push (caller guarantees !full_o)
//   rd_en_i, rd_data_o    pop; rd_data_o is the head word, valid when !empty_o
//   full_o, empty_o       occupancy flags
//   level_o               number of stored words
`ifdef USRT_TX_FIFO_EN
module usrt_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      rd_en_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == (PTR_W+1)'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i && !full_o)  wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (rd_en_i && !empty_o) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full_o) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
  end

endmodule
`endif

// File: rtl/usrt_tx_param.sv
// usrt_tx_param: parametrised USRT serial transmitter.
// Frame on SO: start(0), DATA_W data bits, optional parity, STOP_BITS stop(1);
// every bit is held BAUD_DIV clocks.
//   CLOCK, RESET_N   clock, async active-low reset
//   SEND, TX_DATA    word transfers on an edge with SEND && READY
//   READY            word can be accepted this cycle
//   SO               registered serial output, idles high
//   NINTO            high from start bit through last stop bit
//   DONE             one-cycle pulse after a completed frame
//   FIFO_LEVEL       input FIFO occupancy (USRT_TX_FIFO_EN only)
// Build option: define USRT_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in
// front of the serialiser.
module usrt_tx_param
  import usrt_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int BAUD_DIV    = 1,
  parameter int MSB_FIRST   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  input  logic                          SEND,
  input  logic [DATA_W-1:0]             TX_DATA,
  output logic                          READY,
  output logic                          SO,
  output logic                          NINTO,
  output logic                          DONE
`ifdef USRT_TX_FIFO_EN
 ,output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
`endif
);
  localparam int STOP_CLKS = STOP_BITS * BAUD_DIV;
  localparam int CNT_W     = ($clog2(STOP_CLKS) < 1) ? 1 : $clog2(STOP_CLKS);
  localparam int BIT_W     = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] BAUD_LD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_q;
  logic              so_q, ninto_q, done_q;

  logic              go;
  logic [DATA_W-1:0] wdata;

`ifdef USRT_TX_FIFO_EN
  logic fifo_full, fifo_empty;

  // Serialiser pops whenever idle with data queued; the pop edge is the
  // start-bit edge.
  assign go    = (state_q == IDLE) && !fifo_empty;
  assign READY = !fifo_full;

  usrt_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLOCK),
    .rst_ni    (RESET_N),
    .wr_en_i   (SEND && !fifo_full),
    .wr_data_i (TX_DATA),
    .rd_en_i   (go),
    .rd_data_o (wdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (FIFO_LEVEL)
  );
`else
  assign go    = SEND && (state_q == IDLE);
  assign READY = (state_q == IDLE);
  assign wdata = TX_DATA;
`endif

  // Parity is taken from the word as accepted, not from the shifting copy.
  logic par_bit;
  assign par_bit = (PARITY_MODE == PAR_ODD) ? ~(^wdata) : ^wdata;

  logic              nxt_bit;
  logic [DATA_W-1:0] sh_nxt;
  assign nxt_bit = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
  assign sh_nxt  = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, sh_q[DATA_W-1:1]};

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      so_q    <= 1'b1;
      ninto_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          so_q <= 1'b1;
          if (go) begin
            sh_q    <= wdata;
            par_q   <= par_bit;
            so_q    <= 1'b0;
            ninto_q <= 1'b1;
            baud_q  <= BAUD_LD;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q != '0) baud_q <= baud_q - CNT_ONE;
          else begin
            so_q    <= nxt_bit;
            sh_q    <= sh_nxt;
            bit_q   <= '0;
            baud_q  <= BAUD_LD;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud_q != '0) baud_q <= baud_q - CNT_ONE;
          else if (bit_q == BIT_LAST) begin
            if (PARITY_MODE != PAR_NONE) begin
              so_q    <= par_q;
              baud_q  <= BAUD_LD;
              state_q <= PARITY;
            end else begin
              so_q    <= 1'b1;
              baud_q  <= STOP_LD;
              state_q <= STOP;
            end
          end else begin
            so_q   <= nxt_bit;
            sh_q   <= sh_nxt;
            bit_q  <= bit_q + BIT_ONE;
            baud_q <= BAUD_LD;
          end
        end
        PARITY: begin
          if (baud_q != '0) baud_q <= baud_q - CNT_ONE;
          else begin
            so_q    <= 1'b1;
            baud_q  <= STOP_LD;
            state_q <= STOP;
          end
        end
        STOP: begin
          // The whole stop span is one countdown of STOP_BITS*BAUD_DIV clocks.
          if (baud_q != '0) baud_q <= baud_q - CNT_ONE;
          else begin
            so_q    <= 1'b1;
            ninto_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          sh_q    <= '0;
          par_q   <= 1'b0;
          so_q    <= 1'b1;
          ninto_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SO    = so_q;
  assign NINTO = ninto_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_usrt_tx_param.sv
// tb_usrt_tx_param: three transmitter configurations share SEND/TX_DATA.
// Each accepted word is queued with its transfer edge; a monitor rebuilds
// the expected frame from the framing rules and checks SO/NINTO/DONE/READY
// cycle by cycle, plus start latency and (FIFO build) FIFO_LEVEL.
module tb_usrt_tx_param;
  localparam int NDUT = 3;
`ifdef USRT_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
  localparam int LAT     = 1;
`else
  localparam bit FIFO_ON = 1'b0;
  localparam int LAT     = 0;
`endif
  localparam int W0 = 8,  P0 = 0, S0 = 1, B0 = 1, M0 = 0;
  localparam int W1 = 8,  P1 = 1, S1 = 2, B1 = 4, M1 = 0;
  localparam int W2 = 16, P2 = 2, S2 = 1, B2 = 2, M2 = 1;

  logic        CLOCK = 1'b0;
  logic        RESET_N, SEND;
  logic [15:0] tx_data;
  logic        so [NDUT], ninto [NDUT], done [NDUT], rdy [NDUT];
`ifdef USRT_TX_FIFO_EN
  logic [2:0]  lvl [NDUT];
`endif

  always #5 CLOCK = ~CLOCK;

  int ecnt = 0;
  always @(posedge CLOCK) ecnt <= ecnt + 1;

  usrt_tx_param #(.DATA_W(W0), .PARITY_MODE(P0), .STOP_BITS(S0), .BAUD_DIV(B0),
                  .MSB_FIRST(M0), .FIFO_DEPTH(4)) u0 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .SEND(SEND), .TX_DATA(tx_data[W0-1:0]),
    .READY(rdy[0]), .SO(so[0]), .NINTO(ninto[0]), .DONE(done[0])
`ifdef USRT_TX_FIFO_EN
   ,.FIFO_LEVEL(lvl[0])
`endif
  );
  usrt_tx_param #(.DATA_W(W1), .PARITY_MODE(P1), .STOP_BITS(S1), .BAUD_DIV(B1),
                  .MSB_FIRST(M1), .FIFO_DEPTH(4)) u1 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .SEND(SEND), .TX_DATA(tx_data[W1-1:0]),
    .READY(rdy[1]), .SO(so[1]), .NINTO(ninto[1]), .DONE(done[1])
`ifdef USRT_TX_FIFO_EN
   ,.FIFO_LEVEL(lvl[1])
`endif
  );
  usrt_tx_param #(.DATA_W(W2), .PARITY_MODE(P2), .STOP_BITS(S2), .BAUD_DIV(B2),
                  .MSB_FIRST(M2), .FIFO_DEPTH(4)) u2 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .SEND(SEND), .TX_DATA(tx_data[W2-1:0]),
    .READY(rdy[2]), .SO(so[2]), .NINTO(ninto[2]), .DONE(done[2])
`ifdef USRT_TX_FIFO_EN
   ,.FIFO_LEVEL(lvl[2])
`endif
  );

  function automatic int cfg_w(input int k);
    case (k) 0: return W0; 1: return W1; default: return W2; endcase
  endfunction
  function automatic int cfg_p(input int k);
    case (k) 0: return P0; 1: return P1; default: return P2; endcase
  endfunction
  function automatic int cfg_s(input int k);
    case (k) 0: return S0; 1: return S1; default: return S2; endcase
  endfunction
  function automatic int cfg_b(input int k);
    case (k) 0: return B0; 1: return B1; default: return B2; endcase
  endfunction
  function automatic int cfg_m(input int k);
    case (k) 0: return M0; 1: return M1; default: return M2; endcase
  endfunction

  // Reference frame: list of serial bits in transmission order.
  function automatic void build(input int k, input logic [15:0] d,
                                output logic [31:0] bits, output int n);
    int w, ones;
    w = cfg_w(k);
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < w; i++) begin
      bits[n] = (cfg_m(k) != 0) ? d[w-1-i] : d[i];
      n++;
    end
    if (cfg_p(k) != 0) begin
      ones = 0;
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      bits[n] = (cfg_p(k) == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < cfg_s(k); s++) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  typedef struct { logic [15:0] d; int w; } sb_t;
  sb_t q0[$], q1[$], q2[$];

  function automatic void qpush(input int k, input sb_t it);
    case (k) 0: q0.push_back(it); 1: q1.push_back(it); default: q2.push_back(it); endcase
  endfunction
  function automatic int qsize(input int k);
    case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic sb_t qpop(input int k);
    case (k) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction
  function automatic int qlvl(input int k, input int n);
    int c = 0;
    case (k)
      0: foreach (q0[i]) if (q0[i].w <= n) c++;
      1: foreach (q1[i]) if (q1[i].w <= n) c++;
      default: foreach (q2[i]) if (q2[i].w <= n) c++;
    endcase
    return c;
  endfunction

  int npass = 0, ntot = 0;

  task automatic chk(input bit ok, input string nm, input int k, input int act, input int exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", nm, k, act, exp);
  endtask

  // ---------------- monitor ----------------
  bit          in_fr [NDUT], pend [NDUT], stray [NDUT];
  int          cyc [NDUT], nb [NDUT], bad [NDUT], last_done [NDUT];
  logic [31:0] ef [NDUT];

  task automatic mon_step(input int k);
    int b, es;
    sb_t it;
    b = cfg_b(k);
    if (pend[k]) begin
      chk(done[k] === 1'b1 && ninto[k] === 1'b0 && so[k] === 1'b1 &&
          (FIFO_ON || rdy[k] === 1'b1), "done", k,
          int'({rdy[k], done[k], ninto[k], so[k]}), 4'b1101);
      pend[k] = 1'b0;
      last_done[k] = ecnt;
    end else begin
      if (ninto[k] !== 1'b1) stray[k] = 1'b0;
      if (!in_fr[k] && !stray[k] && ninto[k] === 1'b1) begin
        if (qsize(k) == 0) begin
          chk(1'b0, "stray_frame", k, 1, 0);
          stray[k] = 1'b1;
        end else begin
          it = qpop(k);
          es = (it.w + LAT > last_done[k] + 1) ? it.w + LAT : last_done[k] + 1;
          chk(ecnt == es, "start_edge", k, ecnt, es);
          build(k, it.d, ef[k], nb[k]);
          in_fr[k] = 1'b1;
          cyc[k] = 0;
          bad[k] = 0;
        end
      end
      if (in_fr[k]) begin
        if (so[k] !== ef[k][cyc[k]/b] || ninto[k] !== 1'b1 || done[k] !== 1'b0 ||
            (!FIFO_ON && rdy[k] !== 1'b0)) bad[k]++;
        cyc[k]++;
        if (cyc[k] == nb[k]*b) begin
          chk(bad[k] == 0, "frame_bits", k, bad[k], 0);
          in_fr[k] = 1'b0;
          pend[k] = 1'b1;
        end
      end else if (!stray[k] && (so[k] !== 1'b1 || done[k] !== 1'b0 ||
                                 (!FIFO_ON && rdy[k] !== 1'b1))) begin
        chk(1'b0, "idle", k, int'({rdy[k], done[k], so[k]}), 3'b101);
      end
    end
`ifdef USRT_TX_FIFO_EN
    chk(int'(lvl[k]) == qlvl(k, ecnt) && rdy[k] === (qlvl(k, ecnt) < 4),
        "fifo_level", k, int'(lvl[k]), qlvl(k, ecnt));
`endif
  endtask

  initial begin
    forever begin
      @(negedge CLOCK);
      if (!RESET_N) begin
        q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < NDUT; k++) begin
          in_fr[k] = 1'b0; pend[k] = 1'b0; stray[k] = 1'b0; last_done[k] = -1000;
        end
      end else begin
        for (int k = 0; k < NDUT; k++) mon_step(k);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] d);
    sb_t it;
    @(negedge CLOCK);
    SEND = 1'b1;
    tx_data = d;
    for (int k = 0; k < NDUT; k++) begin
      if (rdy[k] === 1'b1) begin
        it.d = d & 16'((32'd1 << cfg_w(k)) - 1);
        it.w = ecnt + 1;
        qpush(k, it);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLOCK);
      SEND = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int q = 0, c = 0;
    bit busy;
    while (c < 3000 && q < 3) begin
      @(negedge CLOCK);
      SEND = 1'b0;
      busy = 1'b0;
      for (int k = 0; k < NDUT; k++)
        if (qsize(k) != 0 || in_fr[k] || pend[k]) busy = 1'b1;
      q = busy ? 0 : q + 1;
      c++;
    end
    if (q < 3) chk(1'b0, "drain_timeout", 0, c, 3000);
  endtask

  initial begin
    RESET_N = 1'b0;
    SEND    = 1'b0;
    tx_data = '0;
    repeat (2) @(negedge CLOCK);
    for (int k = 0; k < NDUT; k++)
      chk(so[k] === 1'b1 && ninto[k] === 1'b0 && done[k] === 1'b0, "reset_out", k,
          int'({done[k], ninto[k], so[k]}), 3'b001);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    for (int k = 0; k < NDUT; k++) chk(rdy[k] === 1'b1, "reset_ready", k, int'(rdy[k]), 1);

    send(16'h00A5); idle(1); wait_quiet();
    send(16'h0007); idle(1); wait_quiet();
    send(16'h003C); idle(1); wait_quiet();

    // word offered while every serialiser is busy
    send(16'h0000); idle(3); send(16'h00FF); idle(1); wait_quiet();

    // SEND held high: back-to-back frames
    repeat (120) send(16'($urandom));
    idle(1); wait_quiet();

    // burst into the FIFO (without it only the first word is taken)
    send(16'h0011); send(16'h0022); send(16'h0033); send(16'h0044); send(16'h0055);
    idle(1); wait_quiet();

    // reset in the middle of a frame
    send(16'h003C); idle(1);
    repeat (4) @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++)
      chk(so[k] === 1'b1 && ninto[k] === 1'b0 && done[k] === 1'b0, "async_reset", k,
          int'({done[k], ninto[k], so[k]}), 3'b001);
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    send(16'h005A); idle(1); wait_quiet();

    // randomized traffic
    repeat (600) begin
      if ($urandom_range(0, 3) != 0) send(16'($urandom));
      else idle(1);
    end
    idle(1); wait_quiet();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
